// File: rtl/axis_tap_fifo_ram.sv
// Simple dual-port word store for the tap FIFO: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old contents.
module axis_tap_fifo_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_tap_fifo.sv
// Passive AXI4-Stream tap: copies every beat of a monitored link into a frame-aware FIFO
// and replays it on m_axis, truncating or dropping frames instead of stalling the link.
module axis_tap_fifo #(
  parameter int                    DATA_WIDTH           = 8,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
  parameter bit                    ID_ENABLE            = 1'b0,
  parameter int                    ID_WIDTH             = 8,
  parameter bit                    DEST_ENABLE          = 1'b0,
  parameter int                    DEST_WIDTH           = 8,
  parameter bit                    USER_ENABLE          = 1'b1,
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1),
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = USER_WIDTH'(1),
  parameter int                    DEPTH                = 64,
  parameter int                    CNT_WIDTH            = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      tap_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]      tap_axis_tkeep,
  input  logic                       tap_axis_tvalid,
  input  logic                       tap_axis_tready,
  input  logic                       tap_axis_tlast,
  input  logic [ID_WIDTH-1:0]        tap_axis_tid,
  input  logic [DEST_WIDTH-1:0]      tap_axis_tdest,
  input  logic [USER_WIDTH-1:0]      tap_axis_tuser,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [ID_WIDTH-1:0]        m_axis_tid,
  output logic [DEST_WIDTH-1:0]      m_axis_tdest,
  output logic [USER_WIDTH-1:0]      m_axis_tuser,
  output logic [$clog2(DEPTH):0]     status_level,
  output logic                       status_overflow,
  output logic                       status_drop,
  output logic [CNT_WIDTH-1:0]       status_overflow_count,
  output logic [CNT_WIDTH-1:0]       status_drop_count
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
  localparam int KW         = KEEP_ENABLE ? KEEP_WIDTH : 1;
  localparam int IW         = ID_ENABLE ? ID_WIDTH : 1;
  localparam int DW         = DEST_ENABLE ? DEST_WIDTH : 1;
  localparam int UW         = USER_ENABLE ? USER_WIDTH : 1;
  localparam int WORD_WIDTH = DATA_WIDTH + KW + 1 + IW + DW + UW;

  typedef enum logic [1:0] {IDLE, TRANSFER, DROP} state_t;

  state_t                state, state_next;
  logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr, rd_ptr_next, level, occupancy;
  logic                  beat, room, wr_en, wr_term, ovf_evt, drop_evt;
  logic                  q_valid, out_load;
  logic [WORD_WIDTH-1:0] wr_word, rd_word;

  logic [KW-1:0]         tap_keep_f, q_keep, out_keep;
  logic [IW-1:0]         tap_id_f, q_id, out_id;
  logic [DW-1:0]         tap_dest_f, q_dest, out_dest;
  logic [UW-1:0]         tap_user_f, term_user_f, q_user, out_user;
  logic [USER_WIDTH-1:0] term_user;
  logic [DATA_WIDTH-1:0] q_data, out_data;
  logic                  q_last, out_last;

  assign beat  = tap_axis_tvalid && tap_axis_tready;
  assign level = wr_ptr - rd_ptr;
  // The word parked in the output register still occupies one of the DEPTH slots.
  assign occupancy = level + PTR_WIDTH'(m_axis_tvalid);
  assign room      = occupancy < PTR_WIDTH'(DEPTH - 1);

  assign tap_keep_f  = KEEP_ENABLE ? KW'(tap_axis_tkeep) : '0;
  assign tap_id_f    = ID_ENABLE ? IW'(tap_axis_tid) : '0;
  assign tap_dest_f  = DEST_ENABLE ? DW'(tap_axis_tdest) : '0;
  assign tap_user_f  = USER_ENABLE ? UW'(tap_axis_tuser) : '0;
  assign term_user   = (tap_axis_tuser & ~USER_BAD_FRAME_MASK) | (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK);
  assign term_user_f = USER_ENABLE ? UW'(term_user) : '0;

  assign wr_word = wr_term
    ? {{DATA_WIDTH{1'b0}}, KW'(1), 1'b1, tap_id_f, tap_dest_f, term_user_f}
    : {tap_axis_tdata, tap_keep_f, tap_axis_tlast, tap_id_f, tap_dest_f, tap_user_f};

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_term    = 1'b0;
    ovf_evt    = 1'b0;
    drop_evt   = 1'b0;
    case (state)
      IDLE: if (beat) begin
        if (room) begin
          wr_en = 1'b1;
          if (!tap_axis_tlast) state_next = TRANSFER;
        end else begin
          drop_evt = 1'b1;
          if (!tap_axis_tlast) state_next = DROP;
        end
      end
      TRANSFER: if (beat) begin
        wr_en = 1'b1;
        if (room) begin
          if (tap_axis_tlast) state_next = IDLE;
        end else begin
          // Reserved slot takes the bad-frame terminator in place of this beat.
          wr_term    = 1'b1;
          ovf_evt    = 1'b1;
          state_next = tap_axis_tlast ? IDLE : DROP;
        end
      end
      DROP: if (beat && tap_axis_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      wr_ptr                <= '0;
      status_overflow       <= 1'b0;
      status_drop           <= 1'b0;
      status_overflow_count <= '0;
      status_drop_count     <= '0;
    end else begin
      state           <= state_next;
      status_overflow <= ovf_evt;
      status_drop     <= drop_evt;
      if (wr_en) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (ovf_evt) status_overflow_count <= status_overflow_count + CNT_WIDTH'(1);
      if (drop_evt) status_drop_count <= status_drop_count + CNT_WIDTH'(1);
    end
  end

  axis_tap_fifo_ram #(
    .WIDTH      (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_word),
    .rd_addr (rd_ptr_next[ADDR_WIDTH-1:0]),
    .rd_data (rd_word)
  );

  assign {q_data, q_keep, q_last, q_id, q_dest, q_user} = rd_word;

  // The RAM always prefetches the word at the head pointer; q_valid says it was written
  // before the read edge, so a same-cycle write never leaks stale data.
  assign out_load    = q_valid && (!m_axis_tvalid || m_axis_tready);
  assign rd_ptr_next = rd_ptr + PTR_WIDTH'(out_load);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      q_valid       <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr_next;
      q_valid <= (rd_ptr_next != wr_ptr);
      if (out_load) m_axis_tvalid <= 1'b1;
      else if (m_axis_tready) m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (out_load) begin
      out_data <= q_data;
      out_keep <= q_keep;
      out_last <= q_last;
      out_id   <= q_id;
      out_dest <= q_dest;
      out_user <= q_user;
    end
  end

  assign m_axis_tdata = out_data;
  assign m_axis_tkeep = KEEP_ENABLE ? KEEP_WIDTH'(out_keep) : {KEEP_WIDTH{1'b1}};
  assign m_axis_tlast = out_last;
  assign m_axis_tid   = ID_ENABLE ? ID_WIDTH'(out_id) : '0;
  assign m_axis_tdest = DEST_ENABLE ? DEST_WIDTH'(out_dest) : '0;
  assign m_axis_tuser = USER_ENABLE ? USER_WIDTH'(out_user) : '0;
  assign status_level = level;

  logic unused_bits;
  assign unused_bits = ^{tap_axis_tkeep, tap_axis_tid, tap_axis_tdest, tap_axis_tuser,
                         out_keep, out_id, out_dest, out_user};

endmodule

// File: tb/tb_axis_tap_fifo.sv
// Directed bench for axis_tap_fifo at DEPTH=8: latency, truncation, whole-frame drop,
// reset mid-frame, overflow on the last beat and a scoreboarded back-to-back stream.
module tb_axis_tap_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tap_tdata;
  logic       tap_tkeep, tap_tvalid, tap_tready, tap_tlast, tap_tuser;
  logic [7:0] tap_tid, tap_tdest;
  logic [7:0] m_tdata;
  logic       m_tkeep, m_tvalid, m_tready, m_tlast, m_tuser;
  logic [7:0] m_tid, m_tdest;
  logic [3:0] status_level;
  logic       status_overflow, status_drop;
  logic [15:0] ovf_count, drop_count;

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       last;
    logic       user;
  } beat_t;

  beat_t out_q[$];
  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int ovf_seen = 0;
  int drop_seen = 0;

  always #5 clk = ~clk;

  axis_tap_fifo #(.DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .tap_axis_tdata        (tap_tdata),
    .tap_axis_tkeep        (tap_tkeep),
    .tap_axis_tvalid       (tap_tvalid),
    .tap_axis_tready       (tap_tready),
    .tap_axis_tlast        (tap_tlast),
    .tap_axis_tid          (tap_tid),
    .tap_axis_tdest        (tap_tdest),
    .tap_axis_tuser        (tap_tuser),
    .m_axis_tdata          (m_tdata),
    .m_axis_tkeep          (m_tkeep),
    .m_axis_tvalid         (m_tvalid),
    .m_axis_tready         (m_tready),
    .m_axis_tlast          (m_tlast),
    .m_axis_tid            (m_tid),
    .m_axis_tdest          (m_tdest),
    .m_axis_tuser          (m_tuser),
    .status_level          (status_level),
    .status_overflow       (status_overflow),
    .status_drop           (status_drop),
    .status_overflow_count (ovf_count),
    .status_drop_count     (drop_count)
  );

  // Handshakes and status pulses are recorded on the falling edge, between active edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) out_q.push_back(beat_t'({m_tdata, m_tkeep, m_tlast, m_tuser}));
      if (status_overflow) ovf_seen++;
      if (status_drop) drop_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    tap_tdata  = d;
    tap_tlast  = l;
    tap_tuser  = u;
    tap_tvalid = 1'b1;
    tap_tready = 1'b1;
    tick();
    tap_tvalid = 1'b0;
  endtask

  task automatic drain();
    int idle = 0;
    int n = 0;
    m_tready   = 1'b1;
    tap_tvalid = 1'b0;
    while (idle < 3 && n < 200) begin
      tick();
      n++;
      if (!m_tvalid && status_level == 0) idle++;
      else idle = 0;
    end
    total++;
    if (idle < 3) begin
      bad++;
      $display("[TB] FAIL drain_timeout level=%0d valid=%0b want level=0 valid=0", status_level, m_tvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tap_tdata = '0; tap_tkeep = 1'b1; tap_tvalid = 1'b0; tap_tready = 1'b0;
    tap_tlast = 1'b0; tap_tid = '0; tap_tdest = '0; tap_tuser = 1'b0; m_tready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", m_tvalid); end
    total++; if (status_level !== 4'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", status_level); end
    total++; if (ovf_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_ovf_count got=%0d want=0", ovf_count); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_drop_count got=%0d want=0", drop_count); end
    total++; if ({status_overflow, status_drop} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_pulses got=%b want=00", {status_overflow, status_drop});
    end
  endtask

  task automatic test_basic();
    beat_t e;
    out_q.delete(); ovf_seen = 0; drop_seen = 0;
    m_tready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send_beat(8'(i), i == 5, 1'b0);
      if (i <= 2) begin
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL latency_early edge=%0d got=%b want=0", i - 1, m_tvalid); end
      end
      if (i == 3) begin
        total++; if ({m_tvalid, m_tdata} !== {1'b1, 8'h01}) begin
          bad++; $display("[TB] FAIL latency_first got valid=%b data=%h want valid=1 data=01", m_tvalid, m_tdata);
        end
      end
    end
    drain();
    total++; if (out_q.size() != 5) begin bad++; $display("[TB] FAIL basic_len got=%0d want=5", out_q.size()); end
    for (int k = 0; k < 5 && k < out_q.size(); k++) begin
      e = '{data: 8'(k + 1), keep: 1'b1, last: (k == 4), user: 1'b0};
      total++; if (out_q[k] !== e) begin bad++; $display("[TB] FAIL basic_beat%0d got=%h want=%h", k, out_q[k], e); end
    end
    total++; if (ovf_seen != 0 || drop_seen != 0) begin
      bad++; $display("[TB] FAIL basic_pulses got ovf=%0d drop=%0d want 0 0", ovf_seen, drop_seen);
    end
    total++; if ({m_tid, m_tdest} !== 16'h0000) begin bad++; $display("[TB] FAIL basic_tie_off got=%h want=0000", {m_tid, m_tdest}); end
  endtask

  task automatic test_overflow();
    out_q.delete(); ovf_seen = 0; drop_seen = 0;
    m_tready = 1'b0;
    for (int i = 1; i <= 10; i++) send_beat(8'(i), i == 10, 1'b0);
    tick();
    total++; if (status_level !== 4'd7) begin bad++; $display("[TB] FAIL ovf_level got=%0d want=7", status_level); end
    total++; if (ovf_count !== 16'd1) begin bad++; $display("[TB] FAIL ovf_count got=%0d want=1", ovf_count); end
    total++; if (ovf_seen != 1) begin bad++; $display("[TB] FAIL ovf_pulses got=%0d want=1", ovf_seen); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL ovf_drop_count got=%0d want=0", drop_count); end
    total++; if ({m_tvalid, m_tdata} !== {1'b1, 8'h01}) begin
      bad++; $display("[TB] FAIL ovf_hold got valid=%b data=%h want valid=1 data=01", m_tvalid, m_tdata);
    end
  endtask

  task automatic test_drop();
    beat_t e;
    drop_seen = 0;
    for (int i = 0; i < 3; i++) send_beat(8'(8'h21 + i), i == 2, 1'b0);
    tick();
    total++; if (drop_count !== 16'd1) begin bad++; $display("[TB] FAIL drop_count got=%0d want=1", drop_count); end
    total++; if (drop_seen != 1) begin bad++; $display("[TB] FAIL drop_pulses got=%0d want=1", drop_seen); end
    total++; if (status_level !== 4'd7) begin bad++; $display("[TB] FAIL drop_level got=%0d want=7", status_level); end
    drain();
    total++; if (out_q.size() != 8) begin bad++; $display("[TB] FAIL trunc_len got=%0d want=8", out_q.size()); end
    for (int k = 0; k < 8 && k < out_q.size(); k++) begin
      e = (k < 7) ? '{data: 8'(k + 1), keep: 1'b1, last: 1'b0, user: 1'b0}
                  : '{data: 8'h00, keep: 1'b1, last: 1'b1, user: 1'b1};
      total++; if (out_q[k] !== e) begin bad++; $display("[TB] FAIL trunc_beat%0d got=%h want=%h", k, out_q[k], e); end
    end
    out_q.delete();
    send_beat(8'h31, 1'b0, 1'b0);
    send_beat(8'h32, 1'b1, 1'b1);
    drain();
    total++; if (out_q.size() != 2) begin bad++; $display("[TB] FAIL after_drop_len got=%0d want=2", out_q.size()); end
    if (out_q.size() == 2) begin
      total++; if (out_q[0] !== beat_t'({8'h31, 1'b1, 1'b0, 1'b0})) begin bad++; $display("[TB] FAIL after_drop_b0 got=%h want=%h", out_q[0], beat_t'({8'h31, 3'b100})); end
      total++; if (out_q[1] !== beat_t'({8'h32, 1'b1, 1'b1, 1'b1})) begin bad++; $display("[TB] FAIL after_drop_b1 got=%h want=%h", out_q[1], beat_t'({8'h32, 3'b111})); end
    end
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(8'(8'h41 + i), 1'b0, 1'b0);
    tick();
    total++; if (status_level !== 4'd3) begin bad++; $display("[TB] FAIL mid_level_pre got=%0d want=3", status_level); end
    rst = 1'b1;
    tick();
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%b want=0", m_tvalid); end
    total++; if (status_level !== 4'd0) begin bad++; $display("[TB] FAIL mid_level got=%0d want=0", status_level); end
    total++; if ({ovf_count, drop_count} !== 32'd0) begin
      bad++; $display("[TB] FAIL mid_counts got ovf=%0d drop=%0d want 0 0", ovf_count, drop_count);
    end
    rst = 1'b0;
    tick();
    out_q.delete();
    m_tready = 1'b1;
    send_beat(8'h51, 1'b0, 1'b0);
    send_beat(8'h52, 1'b1, 1'b0);
    drain();
    total++; if (out_q.size() != 2) begin bad++; $display("[TB] FAIL mid_after_len got=%0d want=2", out_q.size()); end
    if (out_q.size() == 2) begin
      total++; if (out_q[1] !== beat_t'({8'h52, 1'b1, 1'b1, 1'b0})) begin bad++; $display("[TB] FAIL mid_after_b1 got=%h want=%h", out_q[1], beat_t'({8'h52, 3'b110})); end
    end
  endtask

  task automatic test_ovf_on_last();
    beat_t e;
    out_q.delete(); ovf_seen = 0; drop_seen = 0;
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(8'(8'h61 + i), i == 7, 1'b0);
    tick();
    total++; if (ovf_count !== 16'd1 || ovf_seen != 1) begin
      bad++; $display("[TB] FAIL last_ovf got count=%0d pulses=%0d want 1 1", ovf_count, ovf_seen);
    end
    m_tready = 1'b1;
    tick(); tick();
    send_beat(8'h71, 1'b0, 1'b0);
    send_beat(8'h72, 1'b1, 1'b0);
    drain();
    total++; if (drop_seen != 0 || drop_count !== 16'd0) begin
      bad++; $display("[TB] FAIL last_drop got count=%0d pulses=%0d want 0 0", drop_count, drop_seen);
    end
    total++; if (out_q.size() != 10) begin bad++; $display("[TB] FAIL last_len got=%0d want=10", out_q.size()); end
    for (int k = 0; k < 10 && k < out_q.size(); k++) begin
      if (k < 7)       e = '{data: 8'(8'h61 + k), keep: 1'b1, last: 1'b0, user: 1'b0};
      else if (k == 7) e = '{data: 8'h00, keep: 1'b1, last: 1'b1, user: 1'b1};
      else             e = '{data: 8'(8'h71 + k - 8), keep: 1'b1, last: (k == 9), user: 1'b0};
      total++; if (out_q[k] !== e) begin bad++; $display("[TB] FAIL last_beat%0d got=%h want=%h", k, out_q[k], e); end
    end
  endtask

  task automatic test_back_to_back();
    int f = 0;
    int pos = 0;
    int cyc = 0;
    int max_level = 0;
    logic [7:0] d = 8'h80;
    out_q.delete(); exp_q.delete(); ovf_seen = 0; drop_seen = 0;
    while (f < 40 && cyc < 3000) begin
      m_tready = (cyc % 3 != 2);
      if (cyc % 2 == 0) begin
        tap_tvalid = 1'b1;
        tap_tready = (cyc % 5 != 0);
        tap_tdata  = d;
        tap_tlast  = (pos == f % 4);
        tap_tuser  = (f % 3 == 0) && (pos == f % 4);
        if (tap_tready) begin
          exp_q.push_back('{data: d, keep: 1'b1, last: tap_tlast, user: tap_tuser});
          d = d + 8'd1;
          if (tap_tlast) begin f++; pos = 0; end
          else pos++;
        end
      end else begin
        tap_tvalid = 1'b0;
      end
      tick();
      cyc++;
      if (int'(status_level) > max_level) max_level = int'(status_level);
    end
    drain();
    total++; if (max_level > DEPTH - 1) begin bad++; $display("[TB] FAIL b2b_level got=%0d want<=%0d", max_level, DEPTH - 1); end
    total++; if (ovf_seen != 0 || drop_seen != 0) begin
      bad++; $display("[TB] FAIL b2b_pulses got ovf=%0d drop=%0d want 0 0", ovf_seen, drop_seen);
    end
    total++; if (out_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL b2b_len got=%0d want=%0d", out_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
      total++; if (out_q[k] !== exp_q[k]) begin bad++; $display("[TB] FAIL b2b_beat%0d got=%h want=%h", k, out_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_drop();
    test_reset_mid();
    test_ovf_on_last();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
